// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone register-file slave.
// Holds the transaction FSM state encoding and the wait-state bounds used by
// wb_regfile_slave.
package wb_pkg;

  // Transaction FSM: accept in StIdle, optional stall in StWait, one-cycle
  // termination in StResp.
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } wb_state_e;

  // Largest supported WAIT_STATES value and the counter width that holds it.
  localparam int unsigned WaitStatesMax = 7;
  localparam int unsigned WaitCntW      = 3;

endpackage

// File: rtl/wb_regfile_slave_if.sv
// Wishbone classic bus bundle between one master and the register-file slave.
// Signals:
//   adr      word address (master -> slave)
//   dat_mosi write data (master -> slave)
//   dat_miso read data (slave -> master)
//   sel      byte-lane write enables (master -> slave)
//   we       1 = write, 0 = read (master -> slave)
//   cyc      bus cycle active (master -> slave)
//   stb      strobe, request valid when cyc & stb (master -> slave)
//   ack      normal termination pulse (slave -> master)
//   err      error termination pulse (slave -> master)
interface wb_regfile_slave_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);

  logic [ADDR_W-1:0]   adr;
  logic [DATA_W-1:0]   dat_mosi;
  logic [DATA_W-1:0]   dat_miso;
  logic [DATA_W/8-1:0] sel;
  logic                we;
  logic                cyc;
  logic                stb;
  logic                ack;
  logic                err;

  modport master (
    output adr, dat_mosi, sel, we, cyc, stb,
    input  dat_miso, ack, err
  );

  modport slave (
    input  adr, dat_mosi, sel, we, cyc, stb,
    output dat_miso, ack, err
  );

endinterface

// File: rtl/wb_byte_reg.sv
// One DATA_W-wide register with per-byte write enables and synchronous,
// active-low reset.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset, clears the register
//   be     byte-lane write enables, one bit per 8-bit lane
//   wdata  write data
//   q      current register contents
module wb_byte_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   q
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      for (int unsigned b = 0; b < DATA_W / 8; b++) begin
        if (be[b]) begin
          data_q[8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign q = data_q;

endmodule

// File: rtl/wb_regfile_slave.sv
// Wishbone classic slave fronting a bank of DEPTH byte-writable registers.
// A request (cyc & stb) is captured in idle, optionally stalled for
// WAIT_STATES cycles, then terminated with a one-cycle ack (address < DEPTH)
// or err (address >= DEPTH). Dropping cyc while stalled abandons the access.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset (FSM, capture registers, register bank)
//   bus    Wishbone slave modport (adr, dat_mosi, sel, we, cyc, stb in;
//          dat_miso, ack, err out)
module wb_regfile_slave
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_regfile_slave_if.slave bus
);

  localparam int unsigned SelW = DATA_W / 8;

  if ((DATA_W == 0) || (DATA_W % 8 != 0)) begin : gen_bad_data_w
    $error("DATA_W must be a nonzero multiple of 8");
  end
  if ((DEPTH < 1) || (DEPTH > (1 << ADDR_W))) begin : gen_bad_depth
    $error("DEPTH must lie in 1 .. 2**ADDR_W");
  end
  if (WAIT_STATES > WaitStatesMax) begin : gen_bad_wait
    $error("WAIT_STATES out of range");
  end

  wb_state_e           state_q, state_d;
  logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;

  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [SelW-1:0]   sel_q;
  logic              we_q;

  logic              req;
  logic              capture;
  logic              in_range_q;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] reg_q [DEPTH];

  assign req     = bus.cyc & bus.stb;
  assign capture = (state_q == StIdle) && req;

  // With no wait states the write happens on the capture edge itself, so the
  // write path takes the live bus in idle and the captured copy otherwise.
  logic              from_bus;
  logic [ADDR_W-1:0] t_adr;
  logic [DATA_W-1:0] t_dat;
  logic [SelW-1:0]   t_sel;
  logic              t_we;
  logic              t_in_range;
  logic              wr_en;

  assign from_bus   = (state_q == StIdle);
  assign t_adr      = from_bus ? bus.adr      : adr_q;
  assign t_dat      = from_bus ? bus.dat_mosi : dat_q;
  assign t_sel      = from_bus ? bus.sel      : sel_q;
  assign t_we       = from_bus ? bus.we       : we_q;
  assign t_in_range = (32'(t_adr) < DEPTH);
  assign in_range_q = (32'(adr_q) < DEPTH);

  // Registers are written on the edge that enters StResp.
  assign wr_en = (state_d == StResp) && t_we && t_in_range;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Request capture; later bus changes cannot disturb the access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
    end else if (capture) begin
      adr_q <= bus.adr;
      dat_q <= bus.dat_mosi;
      sel_q <= bus.sel;
      we_q  <= bus.we;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d    = StWait;
            wait_cnt_d = WaitCntW'(WAIT_STATES);
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (!bus.cyc) begin
          state_d    = StIdle;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WaitCntW'(1)) begin
          state_d    = StResp;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q - WaitCntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d    = StIdle;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Outputs: only StResp drives anything; read data is gated by ack.
  always_comb begin
    bus.ack      = 1'b0;
    bus.err      = 1'b0;
    bus.dat_miso = '0;
    if (state_q == StResp) begin
      if (in_range_q) begin
        bus.ack      = 1'b1;
        bus.dat_miso = rdata;
      end else begin
        bus.err = 1'b1;
      end
    end
  end

  // Read mux over the bank; a loop avoids index-width mismatches for any DEPTH.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (32'(adr_q) == i) begin
        rdata = reg_q[i];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : gen_regs
    logic [SelW-1:0] be;

    assign be = (wr_en && (t_adr == ADDR_W'(g))) ? t_sel : '0;

    wb_byte_reg #(
      .DATA_W (DATA_W)
    ) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .be    (be),
      .wdata (t_dat),
      .q     (reg_q[g])
    );
  end

endmodule

// File: tb/tb_wb_regfile_slave.sv
// Scoreboard bench for wb_regfile_slave. Two instances: dut0 (no wait states,
// DEPTH 12) and dut3 (3 wait states, DEPTH 16). Stimulus pushes the expected
// termination (kind, data, cycle) into a per-instance queue; negedge monitors
// pop and compare whenever ack or err is seen.
module tb_wb_regfile_slave;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  longint unsigned cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  wb_regfile_slave_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  wb_regfile_slave_if #(.DATA_W(DW), .ADDR_W(AW)) bus3 ();

  wb_regfile_slave #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(12), .WAIT_STATES(0)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  wb_regfile_slave #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .WAIT_STATES(3)
  ) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  logic [AW-1:0] adr_v [2];
  logic [DW-1:0] dat_v [2];
  logic [3:0]    sel_v [2];
  logic          we_v  [2];
  logic          cyc_v [2];
  logic          stb_v [2];

  assign bus0.adr = adr_v[0];
  assign bus0.dat_mosi = dat_v[0];
  assign bus0.sel = sel_v[0];
  assign bus0.we = we_v[0];
  assign bus0.cyc = cyc_v[0];
  assign bus0.stb = stb_v[0];
  assign bus3.adr = adr_v[1];
  assign bus3.dat_mosi = dat_v[1];
  assign bus3.sel = sel_v[1];
  assign bus3.we = we_v[1];
  assign bus3.cyc = cyc_v[1];
  assign bus3.stb = stb_v[1];

  typedef struct {
    bit              is_err;
    logic [DW-1:0]   data;
    longint unsigned at;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cnt);
    end
  endtask

  task automatic push(int d, bit is_err, logic [DW-1:0] data, longint unsigned at);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    e.at     = at;
    if (d == 0) q0.push_back(e);
    else q3.push_back(e);
  endtask

  task automatic mon(int d, logic ack, logic err, logic [DW-1:0] dat);
    exp_t e;
    int   qs;
    chk($sformatf("dut%0d ack_err_exclusive", d), 64'(ack & err), 64'd0);
    if (ack !== 1'b1) chk($sformatf("dut%0d miso_zero_without_ack", d), 64'(dat), 64'd0);
    if ((ack === 1'b1) || (err === 1'b1)) begin
      qs = (d == 0) ? q0.size() : q3.size();
      if (qs == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut%0d unexpected_response: got ack=%0b err=%0b at cycle %0d, expected none",
                 d, ack, err, cnt);
      end else begin
        if (d == 0) e = q0.pop_front();
        else e = q3.pop_front();
        chk($sformatf("dut%0d kind_err", d), 64'(err), 64'(e.is_err));
        if (!e.is_err) chk($sformatf("dut%0d rdata", d), 64'(dat), 64'(e.data));
        chk($sformatf("dut%0d latency_cycle", d), cnt, e.at);
      end
    end
  endtask

  always @(negedge clk) mon(0, bus0.ack, bus0.err, bus0.dat_miso);
  always @(negedge clk) mon(1, bus3.ack, bus3.err, bus3.dat_miso);

  // One transaction: present it, let the next edge sample it, then scramble the
  // inputs and hold cyc until the response cycle has passed.
  task automatic xact(int d, bit we, logic [AW-1:0] a, logic [DW-1:0] dat, logic [3:0] sel,
                      bit exp_err, logic [DW-1:0] exp_dat);
    int w;
    w = (d == 0) ? 0 : 3;
    adr_v[d] = a;
    dat_v[d] = dat;
    sel_v[d] = sel;
    we_v[d]  = we;
    cyc_v[d] = 1'b1;
    stb_v[d] = 1'b1;
    @(posedge clk);
    #1;
    push(d, exp_err, exp_dat, cnt + longint'(w));
    stb_v[d] = 1'b0;
    adr_v[d] = ~a;
    dat_v[d] = ~dat;
    sel_v[d] = ~sel;
    we_v[d]  = ~we;
    repeat (w + 1) @(posedge clk);
    #1;
    cyc_v[d] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      adr_v[i] = '0;
      dat_v[i] = '0;
      sel_v[i] = '0;
      we_v[i]  = 1'b0;
      cyc_v[i] = 1'b0;
      stb_v[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("dut0 reset_ack", 64'(bus0.ack), 64'd0);
    chk("dut3 reset_err", 64'(bus3.err), 64'd0);
    rst_n = 1'b1;

    // dut0: zero wait states, DEPTH 12. First request right after reset.
    xact(0, 1'b1, 4'd1, 32'hDEADBEEF, 4'hF, 1'b0, 32'hDEADBEEF);
    xact(0, 1'b0, 4'd1, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);
    xact(0, 1'b1, 4'd2, 32'hCAFEBABE, 4'hF, 1'b0, 32'hCAFEBABE);
    xact(0, 1'b1, 4'd2, 32'h11223344, 4'h5, 1'b0, 32'hCA22BA44);
    xact(0, 1'b0, 4'd2, 32'h0, 4'h0, 1'b0, 32'hCA22BA44);
    xact(0, 1'b1, 4'd5, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0);
    xact(0, 1'b1, 4'd11, 32'hA5A5A5A5, 4'hF, 1'b0, 32'hA5A5A5A5);
    xact(0, 1'b1, 4'd13, 32'h00000055, 4'hF, 1'b1, 32'h0);
    xact(0, 1'b1, 4'd12, 32'h12345678, 4'hF, 1'b1, 32'h0);
    xact(0, 1'b0, 4'd13, 32'h0, 4'hF, 1'b1, 32'h0);
    xact(0, 1'b0, 4'd11, 32'h0, 4'hF, 1'b0, 32'hA5A5A5A5);
    xact(0, 1'b0, 4'd5, 32'h0, 4'hF, 1'b0, 32'h0);

    // dut0 back-to-back reads of adr 1 then 2 with cyc/stb held high.
    adr_v[0] = 4'd1;
    we_v[0]  = 1'b0;
    cyc_v[0] = 1'b1;
    stb_v[0] = 1'b1;
    @(posedge clk);
    #1;
    push(0, 1'b0, 32'hDEADBEEF, cnt);
    push(0, 1'b0, 32'hCA22BA44, cnt + 2);
    adr_v[0] = 4'd2;
    repeat (2) @(posedge clk);
    #1;
    stb_v[0] = 1'b0;
    adr_v[0] = 4'd0;
    @(posedge clk);
    #1;
    cyc_v[0] = 1'b0;

    // dut3: three wait states.
    xact(1, 1'b0, 4'd1, 32'h0, 4'hF, 1'b0, 32'h0);
    xact(1, 1'b1, 4'd4, 32'hAAAA5555, 4'hF, 1'b0, 32'hAAAA5555);

    // Abort: cyc dropped two cycles into the wait of a write to adr 4.
    adr_v[1] = 4'd4;
    dat_v[1] = 32'h12345678;
    sel_v[1] = 4'hF;
    we_v[1]  = 1'b1;
    cyc_v[1] = 1'b1;
    stb_v[1] = 1'b1;
    @(posedge clk);
    #1;
    stb_v[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc_v[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    xact(1, 1'b0, 4'd4, 32'h0, 4'hF, 1'b0, 32'hAAAA5555);

    // Reset in the middle of the wait of a write to adr 3.
    xact(1, 1'b1, 4'd3, 32'h00000077, 4'hF, 1'b0, 32'h00000077);
    adr_v[1] = 4'd3;
    dat_v[1] = 32'h00000099;
    sel_v[1] = 4'hF;
    we_v[1]  = 1'b1;
    cyc_v[1] = 1'b1;
    stb_v[1] = 1'b1;
    @(posedge clk);
    #1;
    stb_v[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc_v[1] = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    xact(1, 1'b0, 4'd3, 32'h0, 4'hF, 1'b0, 32'h0);
    xact(0, 1'b0, 4'd1, 32'h0, 4'hF, 1'b0, 32'h0);

    repeat (6) @(posedge clk);
    #1;
    chk("dut0 scoreboard_drained", 64'(q0.size()), 64'd0);
    chk("dut3 scoreboard_drained", 64'(q3.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
